// File: rtl/i2c_master_tx.sv
// Write-only I2C master: pops one 32-bit word (streamed as 4 bytes) per transaction and sends
// START, {addr,W}, 4 data bytes MSB byte first, STOP. Open-drain outputs via output-enables.
module i2c_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] slave_addr,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_dout_valid,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_ADDR  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;
  localparam logic [2:0] S_STOP  = 3'd7;

  logic [2:0]      state;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_idx;
  logic [2:0]      load_tmr;
  logic [7:0]      shreg;
  logic [3:0][7:0] bytes;
  logic [6:0]      addr;
  logic            ack_bit;
  logic            data_phase;
  logic            bus_st, tick, qend;

  // Quarter counter only runs while the bus FSM owns the wires (START..STOP).
  assign bus_st = (state >= S_START);
  assign tick   = bus_st && (div_cnt == DW'(CLK_DIV - 1));
  assign qend   = tick && (qtr == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      qtr        <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      load_tmr   <= '0;
      shreg      <= '0;
      bytes      <= '0;
      addr       <= '0;
      ack_bit    <= 1'b0;
      data_phase <= 1'b0;
      nack_err   <= 1'b0;
    end else begin
      if (!bus_st) begin
        div_cnt <= '0;
        qtr     <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        qtr     <= qtr + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        S_IDLE: if (enable && !fifo_empty) state <= S_POP;
        S_POP: begin
          addr     <= slave_addr;
          byte_idx <= '0;
          load_tmr <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          if (fifo_dout_valid) begin
            bytes[byte_idx] <= fifo_data;
            byte_idx        <= byte_idx + 2'd1;
            load_tmr        <= '0;
            if (byte_idx == 2'd3) begin
              nack_err <= 1'b0;
              state    <= S_START;
            end
          end else if (load_tmr == 3'd7) begin
            state <= S_IDLE;
          end else begin
            load_tmr <= load_tmr + 3'd1;
          end
        end
        S_START: if (qend) begin
          shreg      <= {addr, 1'b0};
          bit_cnt    <= '0;
          byte_idx   <= '0;
          data_phase <= 1'b0;
          state      <= S_ADDR;
        end
        S_ADDR, S_DATA: if (qend) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_ACK;
        end
        S_ACK: begin
          if (tick && qtr == 2'd2) ack_bit <= sda_i;
          if (qend) begin
            bit_cnt <= '0;
            if (ack_bit) begin
              nack_err <= 1'b1;
              state    <= S_STOP;
            end else if (!data_phase) begin
              data_phase <= 1'b1;
              shreg      <= bytes[0];
              state      <= S_DATA;
            end else if (byte_idx == 2'd3) begin
              state <= S_STOP;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              shreg    <= bytes[byte_idx + 2'd1];
              state    <= S_DATA;
            end
          end
        end
        S_STOP: if (qend) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus drive decoded from registered state/quarter, so reset releases the bus at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        sda_oe = (qtr != 2'd0);
        scl_oe = qtr[1];
      end
      S_ADDR, S_DATA: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = ~shreg[7];
      end
      S_ACK:  scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
      S_STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = ~qtr[1];
      end
      default: ;
    endcase
  end

  assign fifo_rd_en = (state == S_POP);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_STOP) && qend;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: FIFO responder, wired-AND bus monitor with an ACK/NACK slave,
// randomized words/addresses/NACK positions checked against decoded bus bytes.
module tb_i2c_master_tx;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [6:0] slave_addr = '0;
  logic       fifo_empty = 1'b1, fifo_rd_en, fifo_dout_valid = 1'b0;
  logic [7:0] fifo_data = '0;
  logic       scl_oe, sda_oe, sda_i, busy, done, nack_err;
  logic       slave_pull = 1'b0;

  always #5 clk = ~clk;
  assign sda_i = ~(sda_oe | slave_pull);

  i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .slave_addr(slave_addr),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .fifo_dout_valid(fifo_dout_valid), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_i(sda_i), .busy(busy), .done(done), .nack_err(nack_err)
  );

  int passes = 0, checks = 0;
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO responder: one word per pop, streamed MSB byte first with random 0/1-cycle gaps.
  logic [31:0] fifo_q[$];
  logic [7:0]  pend[$];
  logic [31:0] pw;
  int  cdown = 0, rd_cnt = 0;
  bit  noresp = 1'b0;
  initial forever begin
    @(negedge clk);
    fifo_dout_valid = 1'b0;
    if (cdown > 0) cdown--;
    else if (pend.size() > 0) begin
      fifo_dout_valid = 1'b1;
      fifo_data = pend.pop_front();
      cdown = $urandom_range(0, 1);
    end
    if (fifo_rd_en) begin
      rd_cnt++;
      if (fifo_q.size() > 0) begin
        pw = fifo_q.pop_front();
        if (!noresp) for (int i = 0; i < 4; i++) pend.push_back(pw[8*(3-i) +: 8]);
        cdown = $urandom_range(0, 1);
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Bus monitor on wired-AND levels; slave ACKs every byte except index nack_at (0 = address).
  logic [7:0] frame[$];
  logic [7:0] cur = '0;
  logic       mscl, msda, pscl = 1'b1, psda = 1'b1;
  int starts = 0, stops = 0, bitn = 0, nack_at = -1;
  initial forever begin
    @(negedge clk);
    mscl = ~scl_oe;
    msda = sda_i;
    if (mscl && pscl && psda && !msda) begin
      starts++; bitn = 0; frame.delete();
    end else if (mscl && pscl && !psda && msda) begin
      stops++;
    end else if (mscl && !pscl) begin
      if (bitn < 8) begin cur = {cur[6:0], msda}; bitn++; end
      else begin frame.push_back(cur); bitn = 0; end
    end else if (!mscl && pscl) begin
      slave_pull = (bitn == 8) && (frame.size() != nack_at);
    end
    pscl = mscl;
    psda = msda;
  end

  task automatic chk_frame(input logic [31:0] w, input logic [6:0] a, input int n);
    logic [7:0] eb[5];
    eb[0] = {a, 1'b0};
    for (int i = 0; i < 4; i++) eb[i+1] = w[8*(3-i) +: 8];
    check("bytes_sent", frame.size(), n);
    for (int i = 0; i < n && i < frame.size(); i++)
      check($sformatf("byte%0d", i), int'(frame[i]), int'(eb[i]));
  endtask

  task automatic txn(input logic [31:0] w, input logic [6:0] a, input int na, input bit chk_clr);
    int s0, st0, t;
    s0 = starts; st0 = stops;
    slave_addr = a; nack_at = na;
    fifo_q.push_back(w);
    if (chk_clr) begin
      t = 0;
      while (starts == s0 && t < 3000) begin @(negedge clk); t++; end
      check("nack_clr_on_start", int'(nack_err), 0);
    end
    t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    chk_frame(w, a, (na < 0) ? 5 : na + 1);
    check("nack_err", int'(nack_err), int'(na >= 0));
    check("one_stop", stops - st0, 1);
  endtask

  initial begin
    int viol, t, gap, s0, st0, r0, na;
    logic [31:0] w1, w2;
    bit prev_nack;
    repeat (3) @(negedge clk);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_nack_err", int'(nack_err), 0);
    rst = 1'b0; enable = 1'b1;

    // Empty FIFO with enable high: nothing happens.
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (fifo_rd_en || busy || scl_oe || sda_oe) viol++;
    end
    check("empty_idle_viol", viol, 0);

    txn(32'hA55A_0FF0, 7'h50, -1, 1'b0);
    txn(32'hA55A_0FF0, 7'h50, 0, 1'b0);
    repeat (20) @(negedge clk);
    check("nack_sticky", int'(nack_err), 1);
    prev_nack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      t = $urandom_range(0, 7);
      na = (t < 3) ? -1 : t - 3;
      txn($urandom, 7'($urandom_range(0, 127)), na, prev_nack);
      prev_nack = (na >= 0);
    end

    // Two words queued back to back.
    nack_at = -1; slave_addr = 7'h2A;
    st0 = stops; r0 = rd_cnt;
    w1 = $urandom; w2 = $urandom;
    fifo_q.push_back(w1); fifo_q.push_back(w2);
    t = 0;
    while (!done && t < 4000) begin @(negedge clk); t++; end
    check("b2b_first_done", int'(done), 1);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!fifo_rd_en && gap < 50);
    check("b2b_pop_gap", gap, 2);
    t = 0;
    while (!done && t < 4000) begin @(negedge clk); t++; end
    check("b2b_second_done", int'(done), 1);
    chk_frame(w2, 7'h2A, 5);
    repeat (5) @(negedge clk);
    check("b2b_pops", rd_cnt - r0, 2);
    check("b2b_stops", stops - st0, 2);

    // Pop with no byte response: word dropped, no bus activity.
    noresp = 1'b1; s0 = starts;
    fifo_q.push_back($urandom);
    t = 0;
    while (!fifo_rd_en && t < 100) begin @(negedge clk); t++; end
    check("noresp_pop", int'(fifo_rd_en), 1);
    repeat (7) @(negedge clk);
    check("noresp_busy_waiting", int'(busy), 1);
    repeat (3) @(negedge clk);
    check("noresp_busy_after", int'(busy), 0);
    repeat (40) @(negedge clk);
    check("noresp_no_start", starts - s0, 0);
    noresp = 1'b0;

    // Reset in the middle of a data byte while SCL is held low.
    s0 = starts; st0 = stops; nack_at = -1; slave_addr = 7'h33;
    fifo_q.push_back($urandom);
    t = 0;
    while ((starts == s0 || frame.size() < 2) && t < 3000) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    t = 0;
    while (!scl_oe && t < 50) begin @(negedge clk); t++; end
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_scl", int'(scl_oe), 0);
    check("rst_mid_sda", int'(sda_oe), 0);
    check("rst_mid_busy", int'(busy), 0);
    viol = 0;
    repeat (5) begin @(negedge clk); if (fifo_rd_en || done) viol++; end
    check("rst_hold_quiet", viol, 0);
    check("rst_no_stop", stops - st0, 0);
    rst = 1'b0;
    txn($urandom, 7'h11, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
